// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: redirect/stall controls, instruction memory port and IF/ID outputs
interface instruction_fetch_stage_if;
  logic        Stall;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Data;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PC_Plus4;
  logic        IFID_Valid;
  logic [5:0]  Opcode;
  logic [5:0]  Function;
  logic        Misalign;
  modport master (
    output Stall, Branch_Taken, Branch_Target, Jump, Jump_Target, Imem_Data,
    input  Imem_Addr, IFID_Instruction, IFID_PC_Plus4, IFID_Valid, Opcode, Function, Misalign
  );
  modport slave (
    input  Stall, Branch_Taken, Branch_Target, Jump, Jump_Target, Imem_Data,
    output Imem_Addr, IFID_Instruction, IFID_PC_Plus4, IFID_Valid, Opcode, Function, Misalign
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register with branch/jump redirect, stall hold and IF/ID pipeline register
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic Clk,
  input logic Reset_n,
  instruction_fetch_stage_if.slave bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, r_instr, w_instr_nxt, r_pc4, w_pc4_nxt, w_target;
  logic r_valid, w_valid_nxt, r_misalign, w_misalign_nxt, w_redirect;
  assign w_redirect = bus.Branch_Taken | bus.Jump;
  assign w_target = bus.Branch_Taken ? bus.Branch_Target : bus.Jump_Target;
  always_comb begin
    w_state_nxt = RUN;
    w_pc_nxt = r_pc;
    w_instr_nxt = r_instr;
    w_pc4_nxt = r_pc4;
    w_valid_nxt = r_valid;
    w_misalign_nxt = r_misalign;
    if (r_state == BOOT) begin
      w_instr_nxt = '0;
      w_pc4_nxt = '0;
      w_valid_nxt = 1'b0;
    end else if (w_redirect) begin
      w_pc_nxt = {w_target[31:2], 2'b00};
      w_instr_nxt = '0;
      w_pc4_nxt = '0;
      w_valid_nxt = 1'b0;
      w_misalign_nxt = r_misalign | (w_target[1:0] != 2'b00);
    end else if (!bus.Stall) begin
      w_pc_nxt = r_pc + 32'd4;
      w_instr_nxt = bus.Imem_Data;
      w_pc4_nxt = r_pc + 32'd4;
      w_valid_nxt = 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= BOOT;
      r_pc <= RESET_PC;
      r_instr <= '0;
      r_pc4 <= '0;
      r_valid <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4 <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end
  assign bus.Imem_Addr = r_pc;
  assign bus.IFID_Instruction = r_instr;
  assign bus.IFID_PC_Plus4 = r_pc4;
  assign bus.IFID_Valid = r_valid;
  assign bus.Opcode = r_instr[31:26];
  assign bus.Function = r_instr[5:0];
  assign bus.Misalign = r_misalign;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed and random fetch/redirect/stall traffic against a spec-level model
module tb_instruction_fetch_stage;
  logic Clk, Reset_n;
  int tests = 0, fails = 0;
  instruction_fetch_stage_if bus();
  instruction_fetch_stage #(.RESET_PC(32'h0)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction
  assign bus.Imem_Data = mem(bus.Imem_Addr);
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic m_valid, m_mis, m_boot;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = 32'h0;
    m_boot = 1'b1;
    m_instr = '0;
    m_pc4 = '0;
    m_valid = 1'b0;
    m_mis = 1'b0;
  endtask
  task automatic model_edge();
    logic [31:0] t;
    if (!Reset_n) return;
    if (m_boot) begin
      m_boot = 1'b0;
      {m_instr, m_pc4, m_valid} = '0;
    end else if (bus.Branch_Taken || bus.Jump) begin
      t = bus.Branch_Taken ? bus.Branch_Target : bus.Jump_Target;
      if (t % 4 != 0) m_mis = 1'b1;
      m_pc = t - (t % 4);
      {m_instr, m_pc4, m_valid} = '0;
    end else if (!bus.Stall) begin
      m_instr = mem(m_pc);
      m_pc4 = m_pc + 4;
      m_valid = 1'b1;
      m_pc = m_pc + 4;
    end
  endtask
  always @(negedge Clk) begin
    chk("imem_addr", bus.Imem_Addr, m_pc);
    chk("ifid_instr", bus.IFID_Instruction, m_instr);
    chk("ifid_pc4", bus.IFID_PC_Plus4, m_pc4);
    chk("ifid_valid", 32'(bus.IFID_Valid), 32'(m_valid));
    chk("opcode", 32'(bus.Opcode), 32'(m_instr[31:26]));
    chk("function", 32'(bus.Function), 32'(m_instr[5:0]));
    chk("misalign", 32'(bus.Misalign), 32'(m_mis));
  end
  task automatic step(input logic s, input logic b, input logic [31:0] bt, input logic j, input logic [31:0] jt);
    bus.Stall = s;
    bus.Branch_Taken = b;
    bus.Branch_Target = bt;
    bus.Jump = j;
    bus.Jump_Target = jt;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask
  task automatic rand_steps(input int n);
    logic [31:0] bt, jt;
    for (int i = 0; i < n; i++) begin
      bt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      jt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, bt, $urandom_range(0, 7) == 0, jt);
    end
  endtask
  initial begin
    Reset_n = 1'b0;
    model_reset();
    {bus.Stall, bus.Branch_Taken, bus.Jump} = '0;
    bus.Branch_Target = '0;
    bus.Jump_Target = '0;
    repeat (2) @(negedge Clk);
    chk("rst_addr", bus.Imem_Addr, 32'h0);
    chk("rst_valid", 32'(bus.IFID_Valid), 32'h0);
    Reset_n = 1'b1;
    step(1, 1, 32'h40, 1, 32'h80);
    chk("boot_addr", bus.Imem_Addr, 32'h0);
    chk("boot_valid", 32'(bus.IFID_Valid), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("seq_addr4", bus.Imem_Addr, 32'h4);
    chk("seq_pc4_4", bus.IFID_PC_Plus4, 32'h4);
    chk("seq_instr0", bus.IFID_Instruction, 32'h1234_5678);
    chk("seq_valid", 32'(bus.IFID_Valid), 32'h1);
    step(0, 0, 0, 0, 0);
    chk("seq_addr8", bus.Imem_Addr, 32'h8);
    chk("seq_pc4_8", bus.IFID_PC_Plus4, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("stall_addr", bus.Imem_Addr, 32'h8);
      chk("stall_pc4", bus.IFID_PC_Plus4, 32'h8);
    end
    step(0, 0, 0, 0, 0);
    chk("resume_addr", bus.Imem_Addr, 32'hC);
    chk("resume_pc4", bus.IFID_PC_Plus4, 32'hC);
    step(1, 1, 32'h40, 0, 0);
    chk("br_stall_addr", bus.Imem_Addr, 32'h40);
    chk("br_bubble_valid", 32'(bus.IFID_Valid), 32'h0);
    chk("br_bubble_op", 32'(bus.Opcode), 32'h0);
    chk("br_bubble_fn", 32'(bus.Function), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("br_fetch_pc4", bus.IFID_PC_Plus4, 32'h44);
    chk("br_fetch_valid", 32'(bus.IFID_Valid), 32'h1);
    step(0, 1, 32'h80, 1, 32'h100);
    chk("br_over_jump", bus.Imem_Addr, 32'h80);
    chk("mis_clear", 32'(bus.Misalign), 32'h0);
    step(0, 0, 0, 1, 32'h103);
    chk("jmp_mis_addr", bus.Imem_Addr, 32'h100);
    chk("jmp_mis_flag", 32'(bus.Misalign), 32'h1);
    step(0, 0, 0, 0, 0);
    chk("mis_sticky", 32'(bus.Misalign), 32'h1);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("wrap_top", bus.Imem_Addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    chk("wrap_addr", bus.Imem_Addr, 32'h0);
    chk("wrap_pc4", bus.IFID_PC_Plus4, 32'h0);
    chk("wrap_valid", 32'(bus.IFID_Valid), 32'h1);
    rand_steps(300);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", bus.Imem_Addr, 32'h0);
    chk("arst_instr", bus.IFID_Instruction, 32'h0);
    chk("arst_pc4", bus.IFID_PC_Plus4, 32'h0);
    chk("arst_valid", 32'(bus.IFID_Valid), 32'h0);
    chk("arst_mis", 32'(bus.Misalign), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("arst_boot_valid", 32'(bus.IFID_Valid), 32'h0);
    step(0, 0, 0, 0, 0);
    chk("arst_first_valid", 32'(bus.IFID_Valid), 32'h1);
    chk("arst_first_pc4", bus.IFID_PC_Plus4, 32'h4);
    rand_steps(300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Stall, input, 1 bit: hold PC and the IF/ID register.
REQ-005 The block SHALL have port Branch_Taken, input, 1 bit: redirect to Branch_Target, resolved downstream.
REQ-006 The block SHALL have port Branch_Target, input, 32 bits: byte address.
REQ-007 The block SHALL have port Jump, input, 1 bit: redirect to Jump_Target (JAL/JR).
REQ-008 The block SHALL have port Jump_Target, input, 32 bits: byte address.
REQ-009 The block SHALL have port Imem_Addr, output, 32 bits: equal to the current PC.
REQ-010 The block SHALL have port Imem_Data, input, 32 bits: instruction word, combinationally valid in the same cycle as Imem_Addr.
REQ-011 The block SHALL have port IFID_Instruction, output, 32 bits: registered instruction.
REQ-012 The block SHALL have port IFID_PC_Plus4, output, 32 bits: registered fetch PC + 4.
REQ-013 The block SHALL have port IFID_Valid, output, 1 bit: 1 = real instruction, 0 = bubble.
REQ-014 The block SHALL have port Opcode, output, 6 bits: IFID_Instruction[31:26], feeding the control unit's Instruction input.
REQ-015 The block SHALL have port Function, output, 6 bits: IFID_Instruction[5:0], feeding the control unit's Function input.
REQ-016 The block SHALL have port Misalign, output, 1 bit: sticky flag set by a misaligned redirect target.

Function
REQ-017 The block SHALL implement a two-state FSM, BOOT and RUN, with BOOT entered on reset.
REQ-018 In BOOT, for exactly one cycle after Reset_n deasserts: PC SHALL hold RESET_PC, the IF/ID register SHALL load a bubble, and the FSM SHALL then go to RUN; Stall, Branch_Taken and Jump SHALL be ignored in BOOT.
REQ-019 A bubble SHALL mean IFID_Instruction = 32'h0 (SLL $0,$0,0, decodes as a NOP), IFID_PC_Plus4 = 0 and IFID_Valid = 0.
REQ-020 Per-cycle priority in RUN SHALL be: Branch_Taken > Jump > Stall > normal fetch.
REQ-021 On normal fetch, at the clock edge: IFID_Instruction <= Imem_Data; IFID_PC_Plus4 <= PC+4; IFID_Valid <= 1; PC <= PC+4.
REQ-022 On Stall (with no redirect), PC and the entire IF/ID register SHALL hold their values.
REQ-023 On Branch_Taken, PC <= {Branch_Target[31:2],2'b00} and the IF/ID register SHALL load a bubble (flush); fetch resumes from the target the next cycle.
REQ-024 On Jump (with Branch_Taken=0), the behaviour SHALL be as REQ-023 using Jump_Target.
REQ-025 A redirect SHALL override Stall: if Stall=1 and Branch_Taken or Jump is 1, the redirect occurs and the flush occurs.
REQ-026 A redirect whose target[1:0] != 0 SHALL set Misalign to 1; Misalign SHALL stay 1 until reset.
REQ-027 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
REQ-028 Opcode and Function SHALL be pure slices of IFID_Instruction with no extra latency.
REQ-029 Latency from Imem_Addr to IFID_Instruction SHALL be one cycle.
REQ-030 Redirect penalty SHALL be exactly one bubble.
REQ-031 Imem_Addr SHALL change only at clock edges or on reset.

Reset
REQ-032 When Reset_n=0, asynchronously and without waiting for Clk: PC = RESET_PC, FSM = BOOT, IFID_Instruction = 0, IFID_PC_Plus4 = 0, IFID_Valid = 0, Misalign = 0.
REQ-033 Reset asserted mid-operation (including during Stall or a redirect) SHALL abandon all in-flight state immediately.
REQ-034 After reset, the first valid IF/ID entry SHALL appear on the second rising edge after Reset_n deasserts.

Verification
REQ-035 Sequential fetch: the bench SHALL apply reset, then Imem_Data = PC-derived words -> required response: after BOOT, Imem_Addr steps 0,4,8,C; IFID_PC_Plus4 = 4,8,C; IFID_Valid = 1.
REQ-036 Stall: the bench SHALL hold Stall=1 for 3 cycles at PC=8 -> required response: Imem_Addr stays 8 and IF/ID keeps the instruction from address 4 (PC_Plus4 = 8); fetch resumes at 8 on release.
REQ-037 Branch under stall: the bench SHALL apply Stall=1 with Branch_Taken=1, Branch_Target=0x40 -> required response: next PC = 0x40, one bubble (Valid=0, Opcode=0, Function=0), then a valid fetch from 0x40.
REQ-038 Branch vs jump: the bench SHALL apply Branch_Taken=1 (target 0x80) together with Jump=1 (target 0x100) -> required response: PC = 0x80.
REQ-039 Misaligned jump and wrap: the bench SHALL apply Jump_Target=0x103 -> required response: PC = 0x100 and Misalign = 1, persisting; the bench SHALL then apply a redirect to 0xFFFFFFFC -> required response: the next PC is 0x0.
REQ-040 Async reset: the bench SHALL drop Reset_n between clock edges mid-stream -> required response: all outputs reach reset values before the next edge, and REQ-034 timing holds afterwards.
